// File: rtl/vec_div_pkg.sv
// Shared types and helpers for the SEW-segmented vector integer divider.
package vec_div_pkg;

  localparam int unsigned LANES_8  = 4;
  localparam int unsigned LANES_16 = 2;
  localparam int unsigned LANES_32 = 1;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    SEW8     = 2'b00,
    SEW16    = 2'b01,
    SEW32    = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  function automatic int unsigned ew_of(sew_e s);
    int unsigned ew;
    case (s)
      SEW8:    ew = 8;
      SEW16:   ew = 16;
      SEW32:   ew = 32;
      default: ew = 0;
    endcase
    return ew;
  endfunction

  // Per-lane sign bits, lane 0 in bit 0; unused lanes read as 0.
  function automatic logic [3:0] lane_msbs(logic [31:0] d, sew_e s);
    logic [3:0] m;
    case (s)
      SEW8:    m = {d[31], d[23], d[15], d[7]};
      SEW16:   m = {2'b00, d[31], d[15]};
      SEW32:   m = {3'b000, d[31]};
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Per-lane all-zero flags, lane 0 in bit 0; unused lanes read as 0.
  function automatic logic [3:0] lane_zero(logic [31:0] d, sew_e s);
    logic [3:0] z;
    case (s)
      SEW8:    z = {d[31:24] == 8'd0, d[23:16] == 8'd0, d[15:8] == 8'd0, d[7:0] == 8'd0};
      SEW16:   z = {2'b00, d[31:16] == 16'd0, d[15:0] == 16'd0};
      SEW32:   z = {3'b000, d == 32'd0};
      default: z = 4'b0000;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/vec_lane_negate.sv
// Combinational SEW-segmented conditional two's-complement negate.
module vec_lane_negate
  import vec_div_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [3:0]  mask_i,
  input  sew_e        sew_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (sew_i)
      SEW8: begin
        for (int i = 0; i < int'(LANES_8); i++) begin
          if (mask_i[i]) data_o[8*i +: 8] = 8'(~data_i[8*i +: 8] + 8'd1);
        end
      end
      SEW16: begin
        for (int i = 0; i < int'(LANES_16); i++) begin
          if (mask_i[i]) data_o[16*i +: 16] = 16'(~data_i[16*i +: 16] + 16'd1);
        end
      end
      SEW32: begin
        if (mask_i[0]) data_o = 32'(~data_i + 32'd1);
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/vec_int_divider.sv
// SEW-segmented radix-2 restoring divider: 4x8, 2x16 or 1x32 lanes in parallel,
// signed or unsigned, with start/busy/done handshake.
module vec_int_divider
  import vec_div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      sew,
  input  logic            div_signed,
  input  logic [XLEN-1:0] data_in_A,
  input  logic [XLEN-1:0] data_in_B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  div_state_e       state_q, state_d;
  sew_e             sew_q, sew_d;
  logic [3:0]       sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0]      a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [31:0]      quot_q, quot_d, rem_q, rem_d;

  sew_e        sew_in;
  logic [3:0]  in_sign_a, in_sign_b, q_neg, r_neg;
  logic [31:0] abs_a, abs_b, q_fix, r_fix, step_a, step_r;
  logic [8:0]  rp8;
  logic [16:0] rp16;
  logic [32:0] rp32;
  logic        ge;

  assign sew_in    = sew_e'(sew);
  assign in_sign_a = div_signed ? lane_msbs(data_in_A, sew_in) : 4'b0000;
  assign in_sign_b = div_signed ? lane_msbs(data_in_B, sew_in) : 4'b0000;

  // Sign flags are zero for unsigned ops, so these masks are no-ops there.
  // A zero divisor keeps the all-ones quotient regardless of signs.
  assign q_neg = (sign_a_q ^ sign_b_q) & ~lane_zero(b_q, sew_q);
  assign r_neg = sign_a_q;

  vec_lane_negate u_abs_a (.data_i(data_in_A), .mask_i(in_sign_a), .sew_i(sew_in), .data_o(abs_a));
  vec_lane_negate u_abs_b (.data_i(data_in_B), .mask_i(in_sign_b), .sew_i(sew_in), .data_o(abs_b));
  vec_lane_negate u_fix_q (.data_i(a_q),       .mask_i(q_neg),     .sew_i(sew_q),  .data_o(q_fix));
  vec_lane_negate u_fix_r (.data_i(r_q),       .mask_i(r_neg),     .sew_i(sew_q),  .data_o(r_fix));

  // One restoring step per lane: dividend shifts out MSB-first, quotient bits shift in at lane LSB.
  always_comb begin
    step_a = a_q;
    step_r = r_q;
    rp8    = '0;
    rp16   = '0;
    rp32   = '0;
    ge     = 1'b0;
    case (sew_q)
      SEW8: begin
        for (int i = 0; i < int'(LANES_8); i++) begin
          rp8 = {r_q[8*i +: 8], a_q[8*i+7]};
          ge  = rp8 >= {1'b0, b_q[8*i +: 8]};
          step_r[8*i +: 8] = ge ? 8'(rp8 - {1'b0, b_q[8*i +: 8]}) : rp8[7:0];
          step_a[8*i +: 8] = {a_q[8*i +: 7], ge};
        end
      end
      SEW16: begin
        for (int i = 0; i < int'(LANES_16); i++) begin
          rp16 = {r_q[16*i +: 16], a_q[16*i+15]};
          ge   = rp16 >= {1'b0, b_q[16*i +: 16]};
          step_r[16*i +: 16] = ge ? 16'(rp16 - {1'b0, b_q[16*i +: 16]}) : rp16[15:0];
          step_a[16*i +: 16] = {a_q[16*i +: 15], ge};
        end
      end
      SEW32: begin
        rp32   = {r_q, a_q[31]};
        ge     = rp32 >= {1'b0, b_q};
        step_r = ge ? 32'(rp32 - {1'b0, b_q}) : rp32[31:0];
        step_a = {a_q[30:0], ge};
      end
      default: begin
        step_a = a_q;
        step_r = r_q;
      end
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    sew_d    = sew_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sew_d    = sew_in;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          a_d      = abs_a;
          b_d      = abs_b;
          r_d      = '0;
          cnt_d    = CNT_W'(ew_of(sew_in) - 32'd1);
          state_d  = (sew_in == SEW_RSVD) ? FIX : CALC;
        end
      end
      CALC: begin
        a_d   = step_a;
        r_d   = step_r;
        cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quot_d  = (sew_q == SEW_RSVD) ? 32'd0 : q_fix;
        rem_d   = (sew_q == SEW_RSVD) ? 32'd0 : r_fix;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sew_q    <= SEW8;
      sign_a_q <= '0;
      sign_b_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      sew_q    <= sew_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = XLEN'(quot_q);
  assign remainder = XLEN'(rem_q);

endmodule
